// File: rtl/bp_pkg.sv
// Shared definitions for the tanh backward-pass block: state encoding and
// saturating fixed-point helpers used by the datapath and the multiplier.
package bp_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SQ    = 3'd1,
        S_DELTA = 3'd2,
        S_LOOP  = 3'd3,
        S_BIAS  = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // The helpers work on 64-bit signed carriers, so words up to 63 bits wide are covered.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] one_val(input int frac);
        return 64'sd1 <<< frac;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                   input logic signed [63:0] y,
                                                   input int                 w);
        logic signed [63:0] s;
        s = x + y;
        if (s > sat_max(w)) return sat_max(w);
        if (s < sat_min(w)) return sat_min(w);
        return s;
    endfunction

endpackage

// File: rtl/fxp_mul.sv
// Combinational signed fixed-point multiply: full-width product, arithmetic
// shift right by FRAC (floor), then clamp to the WIDTH-bit signed range.
module fxp_mul #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);

    localparam logic signed [2*WIDTH-1:0] MAXV = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] MINV = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] ax;
    logic signed [2*WIDTH-1:0] bx;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] shr;

    always_comb begin
        ax   = {{WIDTH{a[WIDTH-1]}}, a};
        bx   = {{WIDTH{b[WIDTH-1]}}, b};
        prod = ax * bx;
        shr  = prod >>> FRAC;
        if (shr > MAXV) begin
            y = MAXV[WIDTH-1:0];
        end else if (shr < MINV) begin
            y = MINV[WIDTH-1:0];
        end else begin
            y = shr[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/bp_tanh_update.sv
// Backward pass of a tanh neuron: delta = err*(1-a^2), SGD update of weights
// and bias, propagated input error, then one write strobe for the weight row.
module bp_tanh_update
    import bp_pkg::*;
#(
    parameter int NUM      = 45,
    parameter int NUM_LSTM = 8,
    parameter int WIDTH    = 32,
    parameter int FRAC     = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [8:0]                      i_addr,
    input  logic signed [WIDTH-1:0]         i_a,
    input  logic signed [WIDTH-1:0]         i_err,
    input  logic signed [WIDTH-1:0]         i_lr,
    input  logic [(NUM+NUM_LSTM)*WIDTH-1:0] i_k,
    input  logic [(NUM+NUM_LSTM)*WIDTH-1:0] i_w,
    input  logic signed [WIDTH-1:0]         i_b,
    output logic                            o_busy,
    output logic signed [WIDTH-1:0]         o_delta,
    output logic [(NUM+NUM_LSTM)*WIDTH-1:0] o_w,
    output logic signed [WIDTH-1:0]         o_b,
    output logic [(NUM+NUM_LSTM)*WIDTH-1:0] o_err_k,
    output logic                            o_wr,
    output logic [8:0]                      o_wr_addr,
    output logic                            o_done,
    output state_t                          o_state
);

    localparam int N  = NUM + NUM_LSTM;
    localparam int JW = (N > 1) ? $clog2(N) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(N - 1);
    localparam logic signed [WIDTH-1:0] ONE = WIDTH'(one_val(FRAC));

    // Handshake: i_start is a request that is taken only while the FSM is in
    // IDLE (o_busy low); requests seen while busy are dropped, never queued.

    state_t state_q, state_d;

    logic signed [WIDTH-1:0] a_q, err_q, lr_q, b_q, one_m_q;
    logic [N*WIDTH-1:0]      k_q, w_q;
    logic [8:0]              addr_q;
    logic [JW-1:0]           j_q;

    logic signed [WIDTH-1:0] k_j, w_j;
    logic signed [WIDTH-1:0] m0_a, m0_b, m0_y;
    logic signed [WIDTH-1:0] m1_a, m1_b, m1_y;
    logic signed [WIDTH-1:0] m2_a, m2_b, m2_y;

    function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] x,
                                                        input logic signed [WIDTH-1:0] y);
        return WIDTH'(sat_add(64'(x), -64'(y), WIDTH));
    endfunction

    always_comb begin
        k_j = k_q[j_q*WIDTH +: WIDTH];
        w_j = w_q[j_q*WIDTH +: WIDTH];
    end

    // Multiplier sharing: m0 squares a in SQ and forms delta*w_j in LOOP;
    // m1 forms err*one_m in DELTA and the gradient delta*k_j in LOOP;
    // m2 scales by the learning rate (gradient in LOOP, delta in BIAS).
    always_comb begin
        m0_a = o_delta;
        m0_b = w_j;
        m1_a = o_delta;
        m1_b = k_j;
        m2_a = lr_q;
        m2_b = m1_y;
        case (state_q)
            S_SQ: begin
                m0_a = a_q;
                m0_b = a_q;
            end
            S_DELTA: begin
                m1_a = err_q;
                m1_b = one_m_q;
            end
            S_BIAS: begin
                m2_b = o_delta;
            end
            default: ;
        endcase
    end

    fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul0 (.a(m0_a), .b(m0_b), .y(m0_y));
    fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul1 (.a(m1_a), .b(m1_b), .y(m1_y));
    fxp_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul2 (.a(m2_a), .b(m2_b), .y(m2_y));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_SQ;
            S_SQ:    state_d = S_DELTA;
            S_DELTA: state_d = S_LOOP;
            S_LOOP:  if (j_q == J_LAST) state_d = S_BIAS;
            S_BIAS:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            err_q   <= '0;
            lr_q    <= '0;
            b_q     <= '0;
            k_q     <= '0;
            w_q     <= '0;
            addr_q  <= '0;
            j_q     <= '0;
            one_m_q <= '0;
            o_delta <= '0;
            o_w     <= '0;
            o_b     <= '0;
            o_err_k <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        a_q    <= i_a;
                        err_q  <= i_err;
                        lr_q   <= i_lr;
                        b_q    <= i_b;
                        k_q    <= i_k;
                        w_q    <= i_w;
                        addr_q <= i_addr;
                        j_q    <= '0;
                    end
                end
                S_SQ: begin
                    one_m_q <= sat_sub(ONE, m0_y);
                end
                S_DELTA: begin
                    o_delta <= m1_y;
                end
                S_LOOP: begin
                    o_w[j_q*WIDTH +: WIDTH]     <= sat_sub(w_j, m2_y);
                    o_err_k[j_q*WIDTH +: WIDTH] <= m0_y;
                    if (j_q != J_LAST) j_q <= j_q + JW'(1);
                end
                S_BIAS: begin
                    o_b <= sat_sub(b_q, m2_y);
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (state_q != S_IDLE);
    assign o_wr      = (state_q == S_WRITE);
    assign o_done    = (state_q == S_DONE);
    assign o_wr_addr = addr_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_bp_tanh_update.sv
// Directed bench for bp_tanh_update at NUM=2, NUM_LSTM=1 (N=3), Q8.24.
module tb_bp_tanh_update;
  import bp_pkg::*;

  localparam int W   = 32;
  localparam int N   = 3;
  localparam int WIN = 20;

  logic           clk;
  logic           rst;
  logic           i_start;
  logic [8:0]     i_addr;
  logic [W-1:0]   i_a, i_err, i_lr, i_b;
  logic [N*W-1:0] i_k, i_w;
  logic           o_busy, o_wr, o_done;
  logic [W-1:0]   o_delta, o_b;
  logic [N*W-1:0] o_w, o_err_k;
  logic [8:0]     o_wr_addr;
  state_t         o_state;

  int n_vec = 0;
  int n_err = 0;

  int         wr_count, done_count, wr_first, wr_second, done_first, done_second;
  logic [8:0] wr_addr_seen;
  logic       busy_tr[1:WIN];
  logic [W-1:0] exp_w[N];
  logic [W-1:0] exp_ek[N];

  bp_tanh_update #(.NUM(2), .NUM_LSTM(1), .WIDTH(W), .FRAC(24)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_addr(i_addr),
    .i_a(i_a), .i_err(i_err), .i_lr(i_lr), .i_k(i_k), .i_w(i_w), .i_b(i_b),
    .o_busy(o_busy), .o_delta(o_delta), .o_w(o_w), .o_b(o_b), .o_err_k(o_err_k),
    .o_wr(o_wr), .o_wr_addr(o_wr_addr), .o_done(o_done), .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_vec(input logic [W-1:0] a, err, lr, k0, k1, k2, w0, w1, w2, b,
                         input logic [8:0] addr);
    i_a = a; i_err = err; i_lr = lr; i_b = b; i_addr = addr;
    i_k = {k2, k1, k0};
    i_w = {w2, w1, w0};
  endtask

  // Edge 0 is the posedge on which the start is accepted.
  task automatic start_op(input bit hold);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) i_start = 1'b0;
  endtask

  // Samples cycles 1..WIN at negedge; mode 1 = busy restart, 2 = input change, 3 = held start.
  task automatic watch(input int mode);
    wr_count = 0; done_count = 0; wr_first = 0; wr_second = 0;
    done_first = 0; done_second = 0; wr_addr_seen = '0;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      busy_tr[c] = o_busy;
      if (o_wr === 1'b1) begin
        wr_count++;
        if (wr_count == 1) begin wr_first = c; wr_addr_seen = o_wr_addr; end
        else if (wr_count == 2) wr_second = c;
      end
      if (o_done === 1'b1) begin
        done_count++;
        if (done_count == 1) done_first = c;
        else if (done_count == 2) done_second = c;
      end
      if (mode == 1 && c == 3) begin
        i_start = 1'b1; i_addr = 9'h00A; i_a = '0; i_err = 32'h7FFFFFFF;
      end
      if (mode == 1 && c == 4) i_start = 1'b0;
      if (mode == 2 && c == 2) begin
        i_k = {N{32'h00000000}}; i_w = {N{32'h7FFFFFFF}};
        i_a = '0; i_err = 32'h7FFFFFFF; i_lr = 32'h7FFFFFFF; i_b = 32'h12345678; i_addr = 9'h1FF;
      end
      if (mode == 3 && c == WIN) i_start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (o_busy !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_timeout: o_busy=%b after %0d cycles, required 0", o_busy, k);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b0; i_start = 1'b0;
    set_vec('0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 9'h000);
    repeat (3) @(negedge clk);
    n_vec++; if (o_state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", o_state, S_IDLE); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_vec++; if (o_wr !== 1'b0 || o_done !== 1'b0) begin n_err++; $display("FAIL reset_strobes: wr=%b done=%b want 0 0", o_wr, o_done); end
    n_vec++; if (o_delta !== '0 || o_b !== '0) begin n_err++; $display("FAIL reset_scalars: delta=%h b=%h want 0 0", o_delta, o_b); end
    n_vec++; if (o_w !== '0 || o_err_k !== '0) begin n_err++; $display("FAIL reset_vectors: w=%h ek=%h want 0", o_w, o_err_k); end
    n_vec++; if (o_wr_addr !== 9'h000) begin n_err++; $display("FAIL reset_addr: got %h want 000", o_wr_addr); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_vec(32'h00800000, 32'h01000000, 32'h00800000,
            32'h01000000, 32'h01000000, 32'h01000000,
            32'h00400000, 32'h00400000, 32'h00400000, 32'h00000000, 9'h005);
    start_op(1'b0);
    watch(0);
    n_vec++; if (o_delta !== 32'h00C00000) begin n_err++; $display("FAIL basic_delta: got %h want 00c00000", o_delta); end
    for (int j = 0; j < N; j++) begin
      n_vec++; if (o_w[j*W +: W] !== 32'hFFE00000) begin n_err++; $display("FAIL basic_w%0d: got %h want ffe00000", j, o_w[j*W +: W]); end
      n_vec++; if (o_err_k[j*W +: W] !== 32'h00300000) begin n_err++; $display("FAIL basic_ek%0d: got %h want 00300000", j, o_err_k[j*W +: W]); end
    end
    n_vec++; if (o_b !== 32'hFFA00000) begin n_err++; $display("FAIL basic_b: got %h want ffa00000", o_b); end
    n_vec++; if (wr_count !== 1 || wr_first !== 7) begin n_err++; $display("FAIL basic_wr: count=%0d cycle=%0d want 1 at 7", wr_count, wr_first); end
    n_vec++; if (wr_addr_seen !== 9'h005) begin n_err++; $display("FAIL basic_wr_addr: got %h want 005", wr_addr_seen); end
    n_vec++; if (done_count !== 1 || done_first !== 8) begin n_err++; $display("FAIL basic_done: count=%0d cycle=%0d want 1 at 8", done_count, done_first); end
    n_vec++; if (busy_tr[1] !== 1'b1 || busy_tr[8] !== 1'b1 || busy_tr[9] !== 1'b0) begin
      n_err++; $display("FAIL basic_busy: c1=%b c8=%b c9=%b want 1 1 0", busy_tr[1], busy_tr[8], busy_tr[9]);
    end
  endtask

  task automatic test_saturated_act();
    exp_w[0] = 32'h00400000; exp_w[1] = 32'hFF234567; exp_w[2] = 32'h7FFFFFF0;
    set_vec(32'h01000000, 32'h01000000, 32'h00800000,
            32'h01000000, 32'h00800000, 32'hFF000000,
            exp_w[0], exp_w[1], exp_w[2], 32'h00123456, 9'h1FD);
    start_op(1'b0);
    watch(0);
    n_vec++; if (o_delta !== 32'h00000000) begin n_err++; $display("FAIL sat_delta: got %h want 0", o_delta); end
    for (int j = 0; j < N; j++) begin
      n_vec++; if (o_w[j*W +: W] !== exp_w[j]) begin n_err++; $display("FAIL sat_w%0d: got %h want %h", j, o_w[j*W +: W], exp_w[j]); end
      n_vec++; if (o_err_k[j*W +: W] !== 32'h0) begin n_err++; $display("FAIL sat_ek%0d: got %h want 0", j, o_err_k[j*W +: W]); end
    end
    n_vec++; if (o_b !== 32'h00123456) begin n_err++; $display("FAIL sat_b: got %h want 00123456", o_b); end
    n_vec++; if (wr_count !== 1 || wr_addr_seen !== 9'h1FD) begin n_err++; $display("FAIL sat_wr: count=%0d addr=%h want 1 1fd", wr_count, wr_addr_seen); end
  endtask

  task automatic test_overflow();
    exp_w[0] = 32'h7FFFFFFF; exp_w[1] = 32'h80000000; exp_w[2] = 32'h00400000;
    exp_ek[0] = 32'h80000010; exp_ek[1] = 32'h7FFFFFFF; exp_ek[2] = 32'hFFC00000;
    set_vec(32'h00000000, 32'hFF000000, 32'h01000000,
            32'h01000000, 32'hFF000000, 32'h00000000,
            32'h7FFFFFF0, 32'h80000000, 32'h00400000, 32'h7FFFFF00, 9'h0C3);
    start_op(1'b0);
    watch(0);
    n_vec++; if (o_delta !== 32'hFF000000) begin n_err++; $display("FAIL ovf_delta: got %h want ff000000", o_delta); end
    for (int j = 0; j < N; j++) begin
      n_vec++; if (o_w[j*W +: W] !== exp_w[j]) begin n_err++; $display("FAIL ovf_w%0d: got %h want %h", j, o_w[j*W +: W], exp_w[j]); end
      n_vec++; if (o_err_k[j*W +: W] !== exp_ek[j]) begin n_err++; $display("FAIL ovf_ek%0d: got %h want %h", j, o_err_k[j*W +: W], exp_ek[j]); end
    end
    n_vec++; if (o_b !== 32'h7FFFFFFF) begin n_err++; $display("FAIL ovf_b: got %h want 7fffffff", o_b); end
  endtask

  // Products of -1 LSB by 0.5 must floor to -1 LSB, not truncate to zero.
  task automatic test_rounding();
    set_vec(32'h00000000, 32'hFFFFFFFF, 32'h00800000,
            32'h01000000, 32'h00000000, 32'h00000000,
            32'h00000000, 32'h01000000, 32'h01000000, 32'h00000000, 9'h011);
    start_op(1'b0);
    watch(0);
    n_vec++; if (o_delta !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rnd_delta: got %h want ffffffff", o_delta); end
    n_vec++; if (o_w[0 +: W] !== 32'h00000001) begin n_err++; $display("FAIL rnd_w0: got %h want 00000001", o_w[0 +: W]); end
    n_vec++; if (o_w[W +: W] !== 32'h01000000) begin n_err++; $display("FAIL rnd_w1: got %h want 01000000", o_w[W +: W]); end
    n_vec++; if (o_err_k[W +: W] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rnd_ek1: got %h want ffffffff", o_err_k[W +: W]); end
    n_vec++; if (o_b !== 32'h00000001) begin n_err++; $display("FAIL rnd_b: got %h want 00000001", o_b); end
  endtask

  task automatic test_busy_reject();
    set_vec(32'h00800000, 32'h01000000, 32'h00800000,
            32'h01000000, 32'h01000000, 32'h01000000,
            32'h00400000, 32'h00400000, 32'h00400000, 32'h00000000, 9'h123);
    start_op(1'b0);
    watch(1);
    n_vec++; if (wr_count !== 1 || wr_first !== 7) begin n_err++; $display("FAIL busy_wr: count=%0d cycle=%0d want 1 at 7", wr_count, wr_first); end
    n_vec++; if (wr_addr_seen !== 9'h123) begin n_err++; $display("FAIL busy_addr: got %h want 123", wr_addr_seen); end
    n_vec++; if (done_count !== 1) begin n_err++; $display("FAIL busy_done: count=%0d want 1", done_count); end
    n_vec++; if (o_delta !== 32'h00C00000 || o_b !== 32'hFFA00000) begin n_err++; $display("FAIL busy_result: delta=%h b=%h want 00c00000 ffa00000", o_delta, o_b); end
  endtask

  task automatic test_snapshot();
    set_vec(32'h00800000, 32'h01000000, 32'h00800000,
            32'h01000000, 32'h01000000, 32'h01000000,
            32'h00400000, 32'h00400000, 32'h00400000, 32'h00000000, 9'h066);
    start_op(1'b0);
    watch(2);
    n_vec++; if (o_delta !== 32'h00C00000) begin n_err++; $display("FAIL snap_delta: got %h want 00c00000", o_delta); end
    for (int j = 0; j < N; j++) begin
      n_vec++; if (o_w[j*W +: W] !== 32'hFFE00000) begin n_err++; $display("FAIL snap_w%0d: got %h want ffe00000", j, o_w[j*W +: W]); end
      n_vec++; if (o_err_k[j*W +: W] !== 32'h00300000) begin n_err++; $display("FAIL snap_ek%0d: got %h want 00300000", j, o_err_k[j*W +: W]); end
    end
    n_vec++; if (o_b !== 32'hFFA00000) begin n_err++; $display("FAIL snap_b: got %h want ffa00000", o_b); end
    n_vec++; if (wr_addr_seen !== 9'h066) begin n_err++; $display("FAIL snap_addr: got %h want 066", wr_addr_seen); end
  endtask

  task automatic test_mid_reset();
    int stray;
    set_vec(32'h00800000, 32'h01000000, 32'h00800000,
            32'h01000000, 32'h01000000, 32'h01000000,
            32'h00400000, 32'h00400000, 32'h00400000, 32'h00000000, 9'h033);
    start_op(1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (o_state !== S_IDLE || o_busy !== 1'b0) begin n_err++; $display("FAIL mrst_state: state=%0d busy=%b want 0 0", o_state, o_busy); end
    n_vec++; if (o_delta !== '0 || o_b !== '0) begin n_err++; $display("FAIL mrst_scalars: delta=%h b=%h want 0 0", o_delta, o_b); end
    n_vec++; if (o_w !== '0 || o_err_k !== '0) begin n_err++; $display("FAIL mrst_vectors: w=%h ek=%h want 0", o_w, o_err_k); end
    n_vec++; if (o_wr !== 1'b0 || o_done !== 1'b0 || o_wr_addr !== 9'h000) begin
      n_err++; $display("FAIL mrst_strobes: wr=%b done=%b addr=%h want 0 0 000", o_wr, o_done, o_wr_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_wr !== 1'b0 || o_busy !== 1'b0) stray++;
    end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL mrst_quiet: %0d active cycles want 0", stray); end
    set_vec(32'h00800000, 32'h01000000, 32'h00800000,
            32'h01000000, 32'h01000000, 32'h01000000,
            32'h00400000, 32'h00400000, 32'h00400000, 32'h00000000, 9'h044);
    start_op(1'b0);
    watch(0);
    n_vec++; if (o_delta !== 32'h00C00000) begin n_err++; $display("FAIL mrst_delta: got %h want 00c00000", o_delta); end
    n_vec++; if (o_w !== {N{32'hFFE00000}}) begin n_err++; $display("FAIL mrst_w: got %h want ffe00000 x3", o_w); end
    n_vec++; if (o_err_k !== {N{32'h00300000}}) begin n_err++; $display("FAIL mrst_ek: got %h want 00300000 x3", o_err_k); end
    n_vec++; if (wr_count !== 1 || wr_first !== 7 || wr_addr_seen !== 9'h044) begin
      n_err++; $display("FAIL mrst_wr: count=%0d cycle=%0d addr=%h want 1 7 044", wr_count, wr_first, wr_addr_seen);
    end
  endtask

  task automatic test_back_to_back();
    set_vec(32'h00800000, 32'h01000000, 32'h00800000,
            32'h01000000, 32'h01000000, 32'h01000000,
            32'h00400000, 32'h00400000, 32'h00400000, 32'h00000000, 9'h0AA);
    start_op(1'b1);
    watch(3);
    n_vec++; if (wr_count !== 2 || wr_first !== 7 || wr_second !== 16) begin
      n_err++; $display("FAIL b2b_wr: count=%0d cycles=%0d,%0d want 2 at 7,16", wr_count, wr_first, wr_second);
    end
    n_vec++; if (done_count !== 2 || done_first !== 8 || done_second !== 17) begin
      n_err++; $display("FAIL b2b_done: count=%0d cycles=%0d,%0d want 2 at 8,17", done_count, done_first, done_second);
    end
    n_vec++; if (busy_tr[9] !== 1'b0 || busy_tr[10] !== 1'b1) begin n_err++; $display("FAIL b2b_gap: c9=%b c10=%b want 0 1", busy_tr[9], busy_tr[10]); end
    wait_idle();
    n_vec++; if (o_w !== {N{32'hFFE00000}} || o_b !== 32'hFFA00000) begin n_err++; $display("FAIL b2b_result: w=%h b=%h", o_w, o_b); end
  endtask

  // sequence and report
  initial begin
    test_reset();
    test_basic();
    test_saturated_act();
    test_overflow();
    test_rounding();
    test_busy_reject();
    test_snapshot();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
